// File: rtl/aca_csu_pkg.sv
// ---------------------------------------------------------------------------
// aca_csu_pkg
// Shared definitions for the ACA-CSU variable-latency adder sequencer:
//   - state_t     : controller FSM states (IDLE, SPEC, FIX, OUT)
//   - DEF_WIDTH   : default operand width
//   - DEF_BLOCK   : default carry-select block width
//   - CNT_W       : width of the optional statistics counters
// ---------------------------------------------------------------------------
package aca_csu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SPEC = 2'd1,
      FIX  = 2'd2,
      OUT  = 2'd3
   } state_t;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_BLOCK = 4;
   localparam int CNT_W     = 16;

endpackage : aca_csu_pkg

// File: rtl/aca_csu_spec_core.sv
// ---------------------------------------------------------------------------
// aca_csu_spec_core
// Combinational ACA-CSU datapath. Each BLOCK-wide slice adds with a carry-in
// predicted from the previous slice alone (its generate with carry-in 0);
// slice 0 uses carry-in 0. The exact sum is formed alongside so the
// controller can detect and repair a misprediction.
// Ports:
//   i_a, i_b   in  WIDTH    registered operands
//   o_spec     out WIDTH+1  speculative sum, MSB = predicted carry-out
//   o_exact    out WIDTH+1  exact sum a+b
//   o_err      out 1        speculative sum differs from exact sum
// ---------------------------------------------------------------------------
module aca_csu_spec_core
   import aca_csu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int BLOCK = DEF_BLOCK
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH:0]   o_spec,
   output logic [WIDTH:0]   o_exact,
   output logic             o_err
);

   localparam int NBLK = WIDTH / BLOCK;

   logic [NBLK-1:0] w_gen;           // block carry-out assuming carry-in 0
   logic [NBLK-1:0] w_cin;           // carry-in actually used by each block
   logic [BLOCK:0]  w_bsum [NBLK];   // block sum incl. its own carry-out

   assign w_cin[0] = 1'b0;

   for (genvar k = 0; k < NBLK; k++) begin : g_blk
      logic [BLOCK:0] w_raw;
      assign w_raw    = {1'b0, i_a[k*BLOCK +: BLOCK]} + {1'b0, i_b[k*BLOCK +: BLOCK]};
      assign w_gen[k] = w_raw[BLOCK];
      assign w_bsum[k] = w_raw + {{BLOCK{1'b0}}, w_cin[k]};
      assign o_spec[k*BLOCK +: BLOCK] = w_bsum[k][BLOCK-1:0];
      if (k >= 1) begin : g_pred
         // Prediction looks back exactly one block; long propagate chains
         // crossing a block boundary are what the FIX cycle repairs.
         assign w_cin[k] = w_gen[k-1];
      end
   end

   assign o_spec[WIDTH] = w_bsum[NBLK-1][BLOCK];
   assign o_exact       = {1'b0, i_a} + {1'b0, i_b};
   assign o_err         = (o_spec != o_exact);

endmodule : aca_csu_spec_core

// File: rtl/aca_csu_vl_ctrl.sv
// ---------------------------------------------------------------------------
// aca_csu_vl_ctrl
// Variable-latency sequencer around aca_csu_spec_core. Accepts one operand
// pair, returns the speculative sum one cycle later when it is correct (or
// approx mode is requested), otherwise spends one more cycle to return the
// exact sum. One transaction in flight at a time.
// Optional feature macro: ACA_CSU_STATS_EN (operation / error counters).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (a, b, approx sampled on accept)
//   out_valid/out_ready result handshake
//   sum                 WIDTH+1 result, MSB is carry-out
//   out_err             speculative sum was wrong for this transaction
//   corrected           result is the exact sum produced in FIX
//   stats_clr, op_cnt, err_cnt   (only with ACA_CSU_STATS_EN)
// ---------------------------------------------------------------------------
module aca_csu_vl_ctrl
   import aca_csu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int BLOCK = DEF_BLOCK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             approx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   sum,
   output logic             out_err,
   output logic             corrected
`ifdef ACA_CSU_STATS_EN
   ,
   input  logic             stats_clr,
   output logic [CNT_W-1:0] op_cnt,
   output logic [CNT_W-1:0] err_cnt
`endif
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_approx;
   logic [WIDTH:0]   r_sum;
   logic             r_err;
   logic             r_corr;

   logic             w_accept;
   logic             w_ld_spec;
   logic             w_ld_fix;
   logic [WIDTH:0]   w_spec;
   logic [WIDTH:0]   w_exact;
   logic             w_err;

   aca_csu_spec_core #(
      .WIDTH (WIDTH),
      .BLOCK (BLOCK)
   ) u_core (
      .i_a     (r_a),
      .i_b     (r_b),
      .o_spec  (w_spec),
      .o_exact (w_exact),
      .o_err   (w_err)
   );

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == OUT);
   assign sum       = r_sum;
   assign out_err   = r_err;
   assign corrected = r_corr;

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_ld_spec   = 1'b0;
      w_ld_fix    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = SPEC;
            end
         end
         SPEC: begin
            if (r_approx || !w_err) begin
               w_ld_spec   = 1'b1;
               w_state_nxt = OUT;
            end else begin
               w_state_nxt = FIX;
            end
         end
         FIX: begin
            w_ld_fix    = 1'b1;
            w_state_nxt = OUT;
         end
         OUT: begin
            if (out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_approx <= 1'b0;
         r_sum    <= '0;
         r_err    <= 1'b0;
         r_corr   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_approx <= approx;
         end
         if (w_ld_spec) begin
            r_sum  <= w_spec;
            r_err  <= w_err;
            r_corr <= 1'b0;
         end else if (w_ld_fix) begin
            r_sum  <= w_exact;
            r_err  <= 1'b1;
            r_corr <= 1'b1;
         end
      end
   end

`ifdef ACA_CSU_STATS_EN
   logic [CNT_W-1:0] r_op_cnt;
   logic [CNT_W-1:0] r_err_cnt;
   logic             w_err_evt;

   // Each transaction passes through SPEC exactly once, so that is where an
   // error is counted, independent of approx mode.
   assign w_err_evt = (r_state == SPEC) && w_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op_cnt  <= '0;
         r_err_cnt <= '0;
      end else if (stats_clr) begin
         r_op_cnt  <= '0;
         r_err_cnt <= '0;
      end else begin
         if (w_accept && (r_op_cnt != '1))   r_op_cnt  <= r_op_cnt + 1'b1;
         if (w_err_evt && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

   assign op_cnt  = r_op_cnt;
   assign err_cnt = r_err_cnt;
`endif

endmodule : aca_csu_vl_ctrl

// File: tb/tb_aca_csu_vl_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aca_csu_vl_ctrl
// Directed, table-driven bench for aca_csu_vl_ctrl (WIDTH=16, BLOCK=4) plus
// hand-written backpressure, mid-transaction reset and (with
// ACA_CSU_STATS_EN) counter sequences.
// ---------------------------------------------------------------------------
module tb_aca_csu_vl_ctrl;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          approx;
   logic          out_valid;
   logic          out_ready;
   logic [W:0]    sum;
   logic          out_err;
   logic          corrected;
`ifdef ACA_CSU_STATS_EN
   logic          stats_clr;
   logic [15:0]   op_cnt;
   logic [15:0]   err_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   aca_csu_vl_ctrl #(.WIDTH(W), .BLOCK(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .approx    (approx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .out_err   (out_err),
      .corrected (corrected)
`ifdef ACA_CSU_STATS_EN
      ,
      .stats_clr (stats_clr),
      .op_cnt    (op_cnt),
      .err_cnt   (err_cnt)
`endif
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        apx;
      logic [16:0] esum;
      logic        eerr;
      logic        ecorr;
      int          elat;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one operand pair at the current cycle, let it be accepted, and
   // wait (bounded) for out_valid. lat = cycles from accept edge to out_valid.
   task automatic issue(input logic [15:0] ta, input logic [15:0] tb_, input logic tapx,
                        output int lat);
      a = ta; b = tb_; approx = tapx; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      a = ~ta; b = ~tb_; approx = ~tapx;   // later changes must be ignored
      lat = 99;
      for (int c = 1; c <= 8; c++) begin
         if (c > 1 || 1) begin
            tick();
            if (out_valid) begin
               lat = c;
               break;
            end
         end
      end
   endtask

   initial begin
      int lat;
      logic [16:0] hold_sum;

      vecs[0] = '{16'h1234, 16'h1111, 1'b0, 17'h02345, 1'b0, 1'b0, 1};
      vecs[1] = '{16'h00FF, 16'h0001, 1'b0, 17'h00100, 1'b1, 1'b1, 2};
      vecs[2] = '{16'h00FF, 16'h0001, 1'b1, 17'h00000, 1'b1, 1'b0, 1};
      vecs[3] = '{16'hFF80, 16'h0080, 1'b0, 17'h10000, 1'b1, 1'b1, 2};
      vecs[4] = '{16'hFF80, 16'h0080, 1'b1, 17'h0F000, 1'b1, 1'b0, 1};
      vecs[5] = '{16'hFFFF, 16'h0001, 1'b1, 17'h0FF00, 1'b1, 1'b0, 1};
      vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE, 1'b0, 1'b0, 1};
      vecs[7] = '{16'h8000, 16'h8000, 1'b0, 17'h10000, 1'b0, 1'b0, 1};
      vecs[8] = '{16'h0F0F, 16'h00F1, 1'b0, 17'h01000, 1'b1, 1'b1, 2};
      vecs[9] = '{16'h0000, 16'h0000, 1'b0, 17'h00000, 1'b0, 1'b0, 1};

      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; approx = 1'b0; out_ready = 1'b1;
`ifdef ACA_CSU_STATS_EN
      stats_clr = 1'b0;
`endif
      repeat (2) tick();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_err", 32'(out_err), 32'd0);
      check("rst_corr", 32'(corrected), 32'd0);
      rst_n = 1'b1;
      tick();

      // Table-driven transactions, consumer always ready.
      for (int i = 0; i < 10; i++) begin
         check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
         issue(vecs[i].a, vecs[i].b, vecs[i].apx, lat);
         check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].elat));
         check($sformatf("v%0d_sum", i), 32'(sum), 32'(vecs[i].esum));
         check($sformatf("v%0d_err", i), 32'(out_err), 32'(vecs[i].eerr));
         check($sformatf("v%0d_corr", i), 32'(corrected), 32'(vecs[i].ecorr));
         check($sformatf("v%0d_busy", i), 32'(in_ready), 32'd0);
         tick();   // out_ready=1: consumed on this edge
         check($sformatf("v%0d_one_valid", i), 32'(out_valid), 32'd0);
         check($sformatf("v%0d_idle", i), 32'(in_ready), 32'd1);
      end

      // Backpressure: hold result for 5 cycles while a new request is offered.
      out_ready = 1'b0;
      issue(16'h00FF, 16'h0001, 1'b0, lat);
      check("bp_lat", 32'(lat), 32'd2);
      in_valid = 1'b1; a = 16'h0001; b = 16'h0002; approx = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         check($sformatf("bp%0d_valid", c), 32'(out_valid), 32'd1);
         check($sformatf("bp%0d_sum", c), 32'(sum), 32'h00100);
         check($sformatf("bp%0d_flags", c), 32'({out_err, corrected}), 32'b11);
         check($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp_release_valid", 32'(out_valid), 32'd0);
      check("bp_release_idle", 32'(in_ready), 32'd1);
      tick();
      check("bp_no_ghost", 32'(out_valid), 32'd0);
      check("bp_no_ghost_idle", 32'(in_ready), 32'd1);

      // Reset during SPEC discards the transaction.
      hold_sum = sum;
      check("pre_rst_sum_nonzero", 32'(hold_sum != 17'd0), 32'd1);
      a = 16'h00FF; b = 16'h0001; approx = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("mid_in_spec", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_sum", 32'(sum), 32'd0);
      check("mid_rst_flags", 32'({out_err, corrected, out_valid}), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         check($sformatf("mid_quiet%0d", c), 32'(out_valid), 32'd0);
      end
      issue(16'h0001, 16'h0001, 1'b0, lat);
      check("post_rst_lat", 32'(lat), 32'd1);
      check("post_rst_sum", 32'(sum), 32'h00002);
      tick();

`ifdef ACA_CSU_STATS_EN
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check("st_rst_op", 32'(op_cnt), 32'd0);
      check("st_rst_err", 32'(err_cnt), 32'd0);
      issue(16'h1234, 16'h1111, 1'b0, lat); tick();
      issue(16'h00FF, 16'h0001, 1'b1, lat); tick();
      issue(16'hFF80, 16'h0080, 1'b0, lat); tick();
      check("st_op_cnt", 32'(op_cnt), 32'd3);
      check("st_err_cnt", 32'(err_cnt), 32'd2);
      stats_clr = 1'b1;
      a = 16'h00FF; b = 16'h0001; approx = 1'b0; in_valid = 1'b1;
      tick();
      stats_clr = 1'b0; in_valid = 1'b0;
      check("st_clr_op", 32'(op_cnt), 32'd0);
      check("st_clr_err", 32'(err_cnt), 32'd0);
      repeat (3) tick();
      check("st_after_clr_op", 32'(op_cnt), 32'd0);
      check("st_after_clr_err", 32'(err_cnt), 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule : tb_aca_csu_vl_ctrl
